// File: rtl/pc_redirect_pkg.sv
// Shared encodings for the PC redirect sequencer: mux selects, request kinds,
// exception causes, vector addresses and the sequencer state type.
package pc_redirect_pkg;

  localparam logic [2:0] SelAlu    = 3'b000;
  localparam logic [2:0] SelAluOut = 3'b001;
  localparam logic [2:0] SelJump   = 3'b010;
  localparam logic [2:0] SelMdr    = 3'b011;
  localparam logic [2:0] SelEpc    = 3'b100;

  localparam logic [1:0] KindSeq    = 2'd0;
  localparam logic [1:0] KindBranch = 2'd1;
  localparam logic [1:0] KindJump   = 2'd2;
  localparam logic [1:0] KindRte    = 2'd3;

  localparam logic [1:0] CauseNone     = 2'd0;
  localparam logic [1:0] CauseOpcode   = 2'd1;
  localparam logic [1:0] CauseOverflow = 2'd2;
  localparam logic [1:0] CauseDiv0     = 2'd3;

  localparam logic [31:0] VecOpcode   = 32'd253;
  localparam logic [31:0] VecOverflow = 32'd254;
  localparam logic [31:0] VecDiv0     = 32'd255;

  typedef enum logic [2:0] {
    StIdle,
    StPcUpd,
    StExcSave,
    StExcAddr,
    StExcWait,
    StExcLoad,
    StExcJump
  } state_e;

  function automatic logic [2:0] kind_to_sel(input logic [1:0] kind);
    logic [2:0] sel;
    sel = SelAlu;
    case (kind)
      KindSeq:    sel = SelAlu;
      KindBranch: sel = SelAluOut;
      KindJump:   sel = SelJump;
      KindRte:    sel = SelEpc;
      default:    sel = SelAlu;
    endcase
    return sel;
  endfunction

  function automatic logic [31:0] cause_to_vec(input logic [1:0] cause);
    logic [31:0] vec;
    vec = '0;
    case (cause)
      CauseOpcode:   vec = VecOpcode;
      CauseOverflow: vec = VecOverflow;
      CauseDiv0:     vec = VecDiv0;
      default:       vec = '0;
    endcase
    return vec;
  endfunction

endpackage

// File: rtl/exc_prio_enc.sv
// Exception priority encoder: opcode > overflow > div0.
// Divide-by-zero trapping is enabled by defining PC_REDIRECT_DIV0_EXC_EN.
module exc_prio_enc
  import pc_redirect_pkg::*;
(
  input  logic       exc_opcode,
  input  logic       exc_overflow,
  input  logic       exc_div0,
  output logic [1:0] cause,
  output logic       valid
);

  always_comb begin
    cause = CauseNone;
    valid = 1'b0;
    if (exc_opcode) begin
      cause = CauseOpcode;
      valid = 1'b1;
    end else if (exc_overflow) begin
      cause = CauseOverflow;
      valid = 1'b1;
    end
`ifdef PC_REDIRECT_DIV0_EXC_EN
    else if (exc_div0) begin
      cause = CauseDiv0;
      valid = 1'b1;
    end
`endif
  end

`ifndef PC_REDIRECT_DIV0_EXC_EN
  logic unused_div0;
  assign unused_div0 = exc_div0;
`endif

endmodule

// File: rtl/pc_redirect_ctrl.sv
// PC-source select / PC and EPC write sequencer, including the exception vector fetch.
// Divide-by-zero trapping is enabled by defining PC_REDIRECT_DIV0_EXC_EN.
module pc_redirect_ctrl
  import pc_redirect_pkg::*;
#(
  parameter int unsigned MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  input  logic [1:0]  req_kind,
  output logic        req_ready,
  input  logic        exc_opcode,
  input  logic        exc_overflow,
  input  logic        exc_div0,
  output logic [2:0]  pc_source_sel,
  output logic        pc_write,
  output logic        epc_write,
  output logic [31:0] vec_addr,
  output logic        vec_addr_sel,
  output logic        mem_read,
  output logic        mdr_load,
  output logic [1:0]  exc_cause,
  output logic        exc_busy
);

  localparam int unsigned CntW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  state_e          state_q;
  logic [CntW-1:0] wait_cnt_q;
  logic [1:0]      enc_cause;
  logic            enc_valid;

  exc_prio_enc u_exc_prio_enc (
    .exc_opcode   (exc_opcode),
    .exc_overflow (exc_overflow),
    .exc_div0     (exc_div0),
    .cause        (enc_cause),
    .valid        (enc_valid)
  );

  assign req_ready = (state_q == StIdle);

  // Outputs are registered alongside the state so each is valid for the whole state cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      wait_cnt_q    <= '0;
      pc_source_sel <= SelAlu;
      pc_write      <= 1'b0;
      epc_write     <= 1'b0;
      vec_addr      <= '0;
      vec_addr_sel  <= 1'b0;
      mem_read      <= 1'b0;
      mdr_load      <= 1'b0;
      exc_cause     <= CauseNone;
      exc_busy      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (enc_valid) begin
            exc_cause <= enc_cause;
            epc_write <= 1'b1;
            exc_busy  <= 1'b1;
            state_q   <= StExcSave;
          end else if (req_valid) begin
            pc_source_sel <= kind_to_sel(req_kind);
            pc_write      <= 1'b1;
            state_q       <= StPcUpd;
          end
        end
        StPcUpd: begin
          pc_write <= 1'b0;
          state_q  <= StIdle;
        end
        StExcSave: begin
          epc_write    <= 1'b0;
          vec_addr     <= cause_to_vec(exc_cause);
          vec_addr_sel <= 1'b1;
          mem_read     <= 1'b1;
          state_q      <= StExcAddr;
        end
        StExcAddr: begin
          wait_cnt_q <= CntW'(MEM_LAT - 1);
          state_q    <= StExcWait;
        end
        StExcWait: begin
          if (wait_cnt_q == '0) begin
            vec_addr_sel <= 1'b0;
            mem_read     <= 1'b0;
            mdr_load     <= 1'b1;
            state_q      <= StExcLoad;
          end else begin
            wait_cnt_q <= wait_cnt_q - CntW'(1);
          end
        end
        StExcLoad: begin
          mdr_load      <= 1'b0;
          pc_write      <= 1'b1;
          pc_source_sel <= SelMdr;
          state_q       <= StExcJump;
        end
        StExcJump: begin
          pc_write <= 1'b0;
          exc_busy <= 1'b0;
          state_q  <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
